// File: rtl/comparator_arbiter.sv
// Two-requester compare service sharing one comparator, round-robin grant.
// Ports: clk/reset; reqN_* request handshakes; respN_* one-entry response
//   buffers; conflict_count saturating contention-cycle counter.
package comparator_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {
      C_EQ   = 2'd0,
      C_LT   = 2'd1,
      C_LTU  = 2'd2,
      C_NONE = 2'd3
   } ComparatorOp;
endpackage

// alu_comparator: combinational compare.
// Ports: op, a, b in; result (compare outcome), err (op was C_NONE).
module alu_comparator
   import comparator_pkg::*;
(
   input  ComparatorOp op,
   input  word_t       a,
   input  word_t       b,
   output logic        result,
   output logic        err
);
   always_comb begin
      result = 1'b0;
      err    = 1'b0;
      unique case (op)
         C_EQ:   result = (a == b);
         C_LT:   result = ($signed(a) < $signed(b));
         C_LTU:  result = (a < b);
         C_NONE: err    = 1'b1;
      endcase
   end
endmodule

module comparator_arbiter
   import comparator_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  ComparatorOp      req0_op,
   input  word_t            req0_a,
   input  word_t            req0_b,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  ComparatorOp      req1_op,
   input  word_t            req1_a,
   input  word_t            req1_b,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic             resp0_out,
   output logic             resp0_err,
   output logic [TAG_W-1:0] resp0_tag,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic             resp1_out,
   output logic             resp1_err,
   output logic [TAG_W-1:0] resp1_tag,
   output logic [15:0]      conflict_count
);
   logic        elig0;
   logic        elig1;
   logic        grant0;
   logic        grant1;
   logic        last_grant;
   logic        sel;
   logic        sel_q;
   ComparatorOp cmp_op;
   word_t       cmp_a;
   word_t       cmp_b;
   logic        cmp_res;
   logic        cmp_err;

   // A requester may issue if its buffer is empty or draining this cycle.
   assign elig0 = req0_valid && (!resp0_valid || resp0_ready);
   assign elig1 = req1_valid && (!resp1_valid || resp1_ready);

   // last_grant==1 means requester 0 wins the next contention.
   assign grant0 = !reset && elig0 && (!elig1 || last_grant);
   assign grant1 = !reset && elig1 && (!elig0 || !last_grant);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Select holds its last value when idle to avoid needless toggling.
   assign sel = grant1 ? 1'b1 : (grant0 ? 1'b0 : sel_q);

   assign cmp_op = sel ? req1_op : req0_op;
   assign cmp_a  = sel ? req1_a  : req0_a;
   assign cmp_b  = sel ? req1_b  : req0_b;

   alu_comparator u_cmp (
      .op     (cmp_op),
      .a      (cmp_a),
      .b      (cmp_b),
      .result (cmp_res),
      .err    (cmp_err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         sel_q <= sel;
         if (grant0)
            last_grant <= 1'b0;
         else if (grant1)
            last_grant <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp0_valid <= 1'b0;
         resp0_out   <= 1'b0;
         resp0_err   <= 1'b0;
         resp0_tag   <= '0;
      end else if (grant0) begin
         resp0_valid <= 1'b1;
         resp0_out   <= cmp_res;
         resp0_err   <= cmp_err;
         resp0_tag   <= req0_tag;
      end else if (resp0_valid && resp0_ready) begin
         resp0_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp1_valid <= 1'b0;
         resp1_out   <= 1'b0;
         resp1_err   <= 1'b0;
         resp1_tag   <= '0;
      end else if (grant1) begin
         resp1_valid <= 1'b1;
         resp1_out   <= cmp_res;
         resp1_err   <= cmp_err;
         resp1_tag   <= req1_tag;
      end else if (resp1_valid && resp1_ready) begin
         resp1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         conflict_count <= '0;
      else if (elig0 && elig1 && conflict_count != 16'hFFFF)
         conflict_count <= conflict_count + 16'd1;
   end
endmodule

// File: tb/tb_comparator_arbiter.sv
// Randomized self-checking bench for comparator_arbiter.
// Compares DUT against a rule-level reference model every cycle.
module tb_comparator_arbiter;
   import comparator_pkg::*;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             v0, v1, r0, r1;
   ComparatorOp      op0, op1;
   word_t            a0, b0, a1, b1;
   logic [TAG_W-1:0] t0, t1;
   logic             req0_ready, req1_ready;
   logic             resp0_valid, resp0_out, resp0_err;
   logic             resp1_valid, resp1_out, resp1_err;
   logic [TAG_W-1:0] resp0_tag, resp1_tag;
   logic [15:0]      conflict_count;

   int checks   = 0;
   int failures = 0;

   int m_valid [2];
   int m_out   [2];
   int m_err   [2];
   int m_tag   [2];
   int m_last;
   int m_cnt;

   always #5 clk = ~clk;

   comparator_arbiter #(.TAG_W(TAG_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .req0_valid     (v0),
      .req0_ready     (req0_ready),
      .req0_op        (op0),
      .req0_a         (a0),
      .req0_b         (b0),
      .req0_tag       (t0),
      .req1_valid     (v1),
      .req1_ready     (req1_ready),
      .req1_op        (op1),
      .req1_a         (a1),
      .req1_b         (b1),
      .req1_tag       (t1),
      .resp0_valid    (resp0_valid),
      .resp0_ready    (r0),
      .resp0_out      (resp0_out),
      .resp0_err      (resp0_err),
      .resp0_tag      (resp0_tag),
      .resp1_valid    (resp1_valid),
      .resp1_ready    (r1),
      .resp1_out      (resp1_out),
      .resp1_err      (resp1_err),
      .resp1_tag      (resp1_tag),
      .conflict_count (conflict_count)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h",
                  tag, obs, exp);
      end
   endtask

   function automatic int ref_cmp(input ComparatorOp op,
                                  input word_t a,
                                  input word_t b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         C_EQ:    return (a == b) ? 1 : 0;
         C_LT:    return (sa < sb) ? 1 : 0;
         C_LTU:   return ({32'd0, a} < {32'd0, b}) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 0;
         m_out[i]   = 0;
         m_err[i]   = 0;
         m_tag[i]   = 0;
      end
      m_last = 1;
      m_cnt  = 0;
   endtask

   task automatic check_outputs(input string p);
      check({p, "_v0"}, 32'(resp0_valid), 32'(m_valid[0]));
      check({p, "_o0"}, 32'(resp0_out), 32'(m_out[0]));
      check({p, "_e0"}, 32'(resp0_err), 32'(m_err[0]));
      check({p, "_t0"}, 32'(resp0_tag), 32'(m_tag[0]));
      check({p, "_v1"}, 32'(resp1_valid), 32'(m_valid[1]));
      check({p, "_o1"}, 32'(resp1_out), 32'(m_out[1]));
      check({p, "_e1"}, 32'(resp1_err), 32'(m_err[1]));
      check({p, "_t1"}, 32'(resp1_tag), 32'(m_tag[1]));
      check({p, "_cnt"}, 32'(conflict_count), 32'(m_cnt));
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic run_cycle(input string p);
      int e0, e1, g;
      #1;
      e0 = (v0 && (m_valid[0] == 0 || r0)) ? 1 : 0;
      e1 = (v1 && (m_valid[1] == 0 || r1)) ? 1 : 0;
      if (e0 && e1)    g = (m_last == 1) ? 0 : 1;
      else if (e0)     g = 0;
      else if (e1)     g = 1;
      else             g = -1;
      check({p, "_rdy0"}, 32'(req0_ready), (g == 0) ? 32'd1 : 32'd0);
      check({p, "_rdy1"}, 32'(req1_ready), (g == 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      if (m_valid[0] != 0 && r0) m_valid[0] = 0;
      if (m_valid[1] != 0 && r1) m_valid[1] = 0;
      if (g == 0) begin
         m_valid[0] = 1;
         m_out[0]   = ref_cmp(op0, a0, b0);
         m_err[0]   = (op0 == C_NONE) ? 1 : 0;
         m_tag[0]   = int'(t0);
         m_last     = 0;
      end else if (g == 1) begin
         m_valid[1] = 1;
         m_out[1]   = ref_cmp(op1, a1, b1);
         m_err[1]   = (op1 == C_NONE) ? 1 : 0;
         m_tag[1]   = int'(t1);
         m_last     = 1;
      end
      if (e0 && e1 && m_cnt < 65535) m_cnt++;
      @(negedge clk);
      check_outputs(p);
   endtask

   task automatic idle_inputs();
      v0 = 0; v1 = 0; r0 = 1; r1 = 1;
      op0 = C_EQ; op1 = C_EQ;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      t0 = 0; t1 = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      v0 = 1; v1 = 1;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_rdy0", 32'(req0_ready), 32'd0);
      check("rst_rdy1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      check_outputs("rst");
      reset = 1'b0;
      idle_inputs();
   endtask

   logic saved_out;
   logic [TAG_W-1:0] saved_tag;

   initial begin
      reset = 1'b0;
      idle_inputs();
      model_reset();
      do_reset();

      // single requester EQ
      v0 = 1; op0 = C_EQ; a0 = 10; b0 = 10; t0 = 3;
      run_cycle("eq");
      check("eq_v", 32'(resp0_valid), 32'd1);
      check("eq_out", 32'(resp0_out), 32'd1);
      check("eq_tag", 32'(resp0_tag), 32'd3);
      check("eq_err", 32'(resp0_err), 32'd0);

      // round-robin contention after reset
      do_reset();
      v0 = 1; v1 = 1;
      op0 = C_LT; a0 = -32'sd7; b0 = -32'sd3;
      op1 = C_LTU; a1 = 32'hFFFF_FFFF; b1 = 0;
      for (int i = 0; i < 4; i++) begin
         t0 = 4'(i); t1 = 4'(i + 8);
         #1;
         check("rr_g0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_g1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
         run_cycle("rr");
      end
      check("rr_cnt", 32'(conflict_count), 32'd4);
      check("rr_lt", 32'(resp0_out), 32'd1);
      check("rr_ltu", 32'(resp1_out), 32'd0);

      // resp0 stalled: no head-of-line blocking on req1
      v1 = 0; r0 = 0; t0 = 5; op0 = C_EQ; a0 = 1; b0 = 2;
      run_cycle("hol_fill");
      saved_out = resp0_out;
      saved_tag = resp0_tag;
      v1 = 1;
      for (int i = 0; i < 3; i++) begin
         a0 = $urandom; t0 = 4'(i);
         a1 = $urandom; b1 = $urandom; t1 = 4'(i);
         #1;
         check("hol_g0", 32'(req0_ready), 32'd0);
         check("hol_g1", 32'(req1_ready), 32'd1);
         run_cycle("hol");
         check("hol_out0", 32'(resp0_out), 32'(saved_out));
         check("hol_tag0", 32'(resp0_tag), 32'(saved_tag));
      end
      r0 = 1;

      // C_NONE reports error
      v0 = 0; v1 = 1; op1 = C_NONE; a1 = 1; b1 = 1; t1 = 4'hA;
      run_cycle("none");
      check("none_out", 32'(resp1_out), 32'd0);
      check("none_err", 32'(resp1_err), 32'd1);
      check("none_tag", 32'(resp1_tag), 32'hA);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         v0 = ($urandom_range(0, 3) != 0);
         v1 = ($urandom_range(0, 3) != 0);
         r0 = ($urandom_range(0, 2) != 0);
         r1 = ($urandom_range(0, 2) != 0);
         op0 = ComparatorOp'($urandom_range(0, 3));
         op1 = ComparatorOp'($urandom_range(0, 3));
         a0 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
         a1 = $urandom;
         b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
         t0 = 4'($urandom); t1 = 4'($urandom);
         run_cycle("rnd");
      end

      // saturation of the contention counter
      do_reset();
      v0 = 1; v1 = 1; r0 = 1; r1 = 1;
      for (int i = 0; i < 65535; i++) begin
         a0 = $urandom; a1 = $urandom;
         run_cycle("sat_fill");
      end
      check("sat_full", 32'(conflict_count), 32'hFFFF);
      run_cycle("sat");
      check("sat_hold", 32'(conflict_count), 32'hFFFF);

      // asynchronous reset in the middle of a cycle
      v0 = 0; v1 = 1; r1 = 0; op1 = C_EQ; a1 = 7; b1 = 7; t1 = 9;
      run_cycle("ar_fill");
      check("ar_pre_v1", 32'(resp1_valid), 32'd1);
      v1 = 1; v0 = 1;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("ar_v1", 32'(resp1_valid), 32'd0);
      check("ar_cnt", 32'(conflict_count), 32'd0);
      check("ar_rdy0", 32'(req0_ready), 32'd0);
      check("ar_rdy1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      check_outputs("ar_hold");
      reset = 1'b0;
      r0 = 1; r1 = 1;
      #1;
      check("ar_first0", 32'(req0_ready), 32'd1);
      run_cycle("ar_post");
      check("ar_post_v0", 32'(resp0_valid), 32'd1);
      v0 = 0; v1 = 0;
      run_cycle("ar_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/comparator_arbiter.md
COMPARATOR_ARBITER -- requirements
Module: comparator_arbiter

Interface
REQ-001 Parameter TAG_W, default 4, width of the requester tag carried unchanged from request to response.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents a compare.
REQ-005 reqN_ready  output  1  compare from requester N accepted this cycle when reqN_valid && reqN_ready.
REQ-006 reqN_op  input  ComparatorOp  C_EQ / C_LT / C_LTU / C_NONE.
REQ-007 reqN_a, reqN_b  input  Word (32)  operands.
REQ-008 reqN_tag  input  TAG_W  opaque requester tag.
REQ-009 respN_valid  output  1  response buffer N holds a result.
REQ-010 respN_ready  input  1  requester N consumes the response when respN_valid && respN_ready.
REQ-011 respN_out  output  1  comparison result.
REQ-012 respN_err  output  1  request carried C_NONE.
REQ-013 respN_tag  output  TAG_W  tag of the request that produced the response.
REQ-014 conflict_count  output  16  saturating count of contention cycles.

Function
REQ-015 The block shall contain exactly one alu_comparator instance, shared by both requesters through a 2:1 operand/op mux.
REQ-016 Requester N shall be eligible when reqN_valid and (respN_valid==0 or respN_ready==1).
REQ-017 At most one requester shall be granted per cycle; reqN_ready shall be 1 only for the granted requester.
REQ-018 Only one eligible requester: it is granted.
REQ-019 Both eligible: grant the requester not recorded in last_grant (round-robin); last_grant updates to the granted index on acceptance only.
REQ-020 Neither eligible: no grant; last_grant and comparator inputs do not matter (mux select holds).
REQ-021 reqN_ready may depend combinationally on reqN_valid, respN_valid, respN_ready and last_grant; it shall not depend on operands, op or tag.
REQ-022 On acceptance at edge E, respN_valid shall be 1 after E with respN_out = comparator result, respN_tag = reqN_tag; latency exactly one cycle.
REQ-023 Results: C_EQ a==b; C_LT signed a<b; C_LTU unsigned a<b.
REQ-024 C_NONE: accepted normally; respN_out=0, respN_err=1; all other ops respN_err=0.
REQ-025 Response buffer N is one entry; cleared at an edge where respN_valid && respN_ready and no new acceptance for N; when consume and new acceptance coincide, the new result replaces the old (back-to-back throughput 1/cycle per requester).
REQ-026 Response outputs shall be stable while respN_valid && !respN_ready.
REQ-027 Requester N whose buffer is full and respN_ready=0 shall never be granted; the other requester shall be granted if eligible (no head-of-line blocking).
REQ-028 conflict_count shall increment by 1 each cycle both requesters are eligible, saturating at 16'hFFFF.

Reset
REQ-029 reset=1 shall immediately clear respN_valid, respN_out, respN_err, respN_tag to 0, conflict_count to 0, last_grant to 1 (requester 0 wins first contention); reqN_ready=0 while reset is high.
REQ-030 Reset mid-operation shall discard buffered responses and any in-flight acceptance; no response from before reset shall appear after release.

Verification
REQ-031 req0 only, op=C_EQ, a=10, b=10, tag=3 -> req0_ready=1; next cycle resp0_valid=1, out=1, tag=3, err=0.
REQ-032 Both valid every cycle for 4 cycles, resp ready=1 -> grants 0,1,0,1; conflict_count=4; results C_LT a=-7,b=-3 ->1, C_LTU a=-1,b=0 ->0.
REQ-033 resp0_ready=0 with resp0 full, both valid -> req1 granted every cycle, req0_ready=0, resp0 outputs stable.
REQ-034 op=C_NONE, a=1, b=1 -> resp out=0, err=1, tag preserved.
REQ-035 conflict_count preloaded by 65535 contention cycles, one more -> stays 16'hFFFF.
REQ-036 reset asserted asynchronously mid-cycle with resp1_valid=1 -> resp1_valid=0 immediately, conflict_count=0; after release first contention grants req0.
